// File: rtl/mips_id_stage.sv
// Instruction-decode stage of the MIPS-lab pipeline.
// Decodes the instruction into control signals and holds the 32x32
// register file that the WB stage writes. The decode and operand paths are
// combinational. The only state is the register file.
// Optional feature: define ID_EARLY_BRANCH_EN to resolve branches in ID
// (Br_Taken). Otherwise Br_Taken is tied low.
module mips_id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction,
    input  logic [31:0] WB_Data,
    input  logic [4:0]  WB_Dest,
    input  logic        WB_Write_Enable,
    output logic [31:0] Val1,
    output logic [31:0] Val2,
    output logic [31:0] Reg2,
    output logic [4:0]  Dest,
    output logic [1:0]  Branch_Type,
    output logic        Br_Taken,
    output logic [3:0]  EXE_CMD,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic        WB_EN
);

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    logic [5:0]  op;
    logic [4:0]  rd_idx;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  src2_idx;
    logic [15:0] imm;
    logic        is_imm;
    logic        src2_is_rd;

    logic [31:0] rf_reg [1:31];
    logic [31:0] rf_view [32];
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] src2_data;

    assign op     = Instruction[31:26];
    assign rd_idx = Instruction[25:21];
    assign rs_idx = Instruction[20:16];
    assign rt_idx = Instruction[15:11];
    assign imm    = Instruction[15:0];

    // Register file storage: R0 has no storage, reset clears and drops any same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (WB_Write_Enable && (WB_Dest != 5'd0)) begin
            rf_reg[WB_Dest] <= WB_Data;
        end
    end

    // Flat read view with R0 hard-wired to zero
    assign rf_view[0] = '0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_rf_view
            assign rf_view[gi] = rf_reg[gi];
        end
    endgenerate

    // Write-first bypass: a read of the register being written this cycle sees WB_Data
    assign rs_data   = (WB_Write_Enable && (rs_idx != 5'd0) && (rs_idx == WB_Dest))
                       ? WB_Data : rf_view[rs_idx];
    assign rt_data   = (WB_Write_Enable && (rt_idx != 5'd0) && (rt_idx == WB_Dest))
                       ? WB_Data : rf_view[rt_idx];
    assign src2_idx  = src2_is_rd ? rd_idx : rt_idx;
    assign src2_data = (WB_Write_Enable && (src2_idx != 5'd0) && (src2_idx == WB_Dest))
                       ? WB_Data : rf_view[src2_idx];

    // Opcode decode. Unknown opcodes fall through to the all-zero NOP defaults
    always_comb begin
        EXE_CMD     = 4'b0000;
        WB_EN       = 1'b0;
        MEM_R_EN    = 1'b0;
        MEM_W_EN    = 1'b0;
        Branch_Type = 2'b00;
        is_imm      = 1'b0;
        src2_is_rd  = 1'b0;
        case (op)
            OP_NOP:  ;
            OP_ADD:  begin EXE_CMD = 4'b0000; WB_EN = 1'b1; end
            OP_SUB:  begin EXE_CMD = 4'b0010; WB_EN = 1'b1; end
            OP_AND:  begin EXE_CMD = 4'b0100; WB_EN = 1'b1; end
            OP_OR:   begin EXE_CMD = 4'b0101; WB_EN = 1'b1; end
            OP_NOR:  begin EXE_CMD = 4'b0110; WB_EN = 1'b1; end
            OP_XOR:  begin EXE_CMD = 4'b0111; WB_EN = 1'b1; end
            OP_SLA:  begin EXE_CMD = 4'b1000; WB_EN = 1'b1; end
            OP_SLL:  begin EXE_CMD = 4'b1000; WB_EN = 1'b1; end
            OP_SRA:  begin EXE_CMD = 4'b1001; WB_EN = 1'b1; end
            OP_SRL:  begin EXE_CMD = 4'b1010; WB_EN = 1'b1; end
            OP_ADDI: begin EXE_CMD = 4'b0000; WB_EN = 1'b1; is_imm = 1'b1; end
            OP_SUBI: begin EXE_CMD = 4'b0010; WB_EN = 1'b1; is_imm = 1'b1; end
            OP_LD:   begin WB_EN = 1'b1; MEM_R_EN = 1'b1; is_imm = 1'b1; end
            OP_ST:   begin MEM_W_EN = 1'b1; is_imm = 1'b1; src2_is_rd = 1'b1; end
            OP_BEZ:  begin Branch_Type = 2'b01; is_imm = 1'b1; src2_is_rd = 1'b1; end
            OP_BNE:  begin Branch_Type = 2'b10; is_imm = 1'b1; src2_is_rd = 1'b1; end
            OP_JMP:  begin Branch_Type = 2'b11; is_imm = 1'b1; end
            default: ;
        endcase
    end

    assign Val1 = rs_data;
    assign Val2 = is_imm ? {{16{imm[15]}}, imm} : rt_data;
    assign Reg2 = src2_data;
    assign Dest = rd_idx;

`ifdef ID_EARLY_BRANCH_EN
    // Early branch resolution on the bypassed operands
    always_comb begin
        case (Branch_Type)
            2'b01:   Br_Taken = (rs_data == 32'd0);
            2'b10:   Br_Taken = (rs_data != src2_data);
            2'b11:   Br_Taken = 1'b1;
            default: Br_Taken = 1'b0;
        endcase
    end
`else
    assign Br_Taken = 1'b0;
`endif

endmodule

// File: tb/tb_mips_id_stage.sv
// Testbench for mips_id_stage: directed scenarios plus randomized traffic
// checked against a table-driven reference model with its own register array.
module tb_mips_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instruction;
    logic [31:0] WB_Data;
    logic [4:0]  WB_Dest;
    logic        WB_Write_Enable;
    logic [31:0] Val1;
    logic [31:0] Val2;
    logic [31:0] Reg2;
    logic [4:0]  Dest;
    logic [1:0]  Branch_Type;
    logic        Br_Taken;
    logic [3:0]  EXE_CMD;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        WB_EN;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // reference model state
    logic [31:0] m_rf [32];
    logic [3:0]  t_cmd [64];
    logic        t_wb  [64];
    logic        t_mr  [64];
    logic        t_mw  [64];
    logic [1:0]  t_bt  [64];
    logic        t_imm [64];
    logic        t_rd2 [64];
    logic [5:0]  valid_ops [18];

    mips_id_stage dut (
        .clk(clk),
        .rst(rst),
        .Instruction(Instruction),
        .WB_Data(WB_Data),
        .WB_Dest(WB_Dest),
        .WB_Write_Enable(WB_Write_Enable),
        .Val1(Val1),
        .Val2(Val2),
        .Reg2(Reg2),
        .Dest(Dest),
        .Branch_Type(Branch_Type),
        .Br_Taken(Br_Taken),
        .EXE_CMD(EXE_CMD),
        .MEM_R_EN(MEM_R_EN),
        .MEM_W_EN(MEM_W_EN),
        .WB_EN(WB_EN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (txn %0d)", tag, got, exp, txn);
        end
    endtask

    function automatic void set_op(input int op, input logic [3:0] cmd, input logic wb,
                                   input logic mr, input logic mw, input logic [1:0] bt,
                                   input logic im, input logic r2);
        t_cmd[op] = cmd; t_wb[op] = wb; t_mr[op] = mr; t_mw[op] = mw;
        t_bt[op] = bt; t_imm[op] = im; t_rd2[op] = r2;
    endfunction

    // register read as seen in the current cycle, including same-cycle write data
    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (WB_Write_Enable && (WB_Dest == idx)) return WB_Data;
        return m_rf[idx];
    endfunction

    // drive inputs, then check every output at the falling edge against the model
    task automatic cyc(input logic [31:0] instr, input logic we, input logic [4:0] wdest,
                       input logic [31:0] wdata, input logic r, input logic do_chk);
        int op;
        logic [31:0] e_v1, e_v2, e_r2;
        logic [4:0]  s2;
        logic        e_bt;
        Instruction = instr; WB_Write_Enable = we; WB_Dest = wdest; WB_Data = wdata; rst = r;
        @(negedge clk);
        txn++;
        op   = int'(instr[31:26]);
        s2   = t_rd2[op] ? instr[25:21] : instr[15:11];
        e_v1 = m_read(instr[20:16]);
        e_r2 = m_read(s2);
        e_v2 = t_imm[op] ? {{16{instr[15]}}, instr[15:0]} : m_read(instr[15:11]);
        e_bt = 1'b0;
`ifdef ID_EARLY_BRANCH_EN
        if (t_bt[op] == 2'b11) e_bt = 1'b1;
        else if (t_bt[op] == 2'b01) e_bt = (e_v1 == 32'd0);
        else if (t_bt[op] == 2'b10) e_bt = (e_v1 != e_r2);
`endif
        $display("txn %0d instr=0x%08h we=%0b dest=%0d data=0x%08h rst=%0b val1=0x%08h val2=0x%08h reg2=0x%08h",
                 txn, instr, we, wdest, wdata, r, Val1, Val2, Reg2);
        if (do_chk) begin
            chk("val1", Val1, e_v1);
            chk("val2", Val2, e_v2);
            chk("reg2", Reg2, e_r2);
            chk("dest", 32'(Dest), 32'(instr[25:21]));
            chk("exe_cmd", 32'(EXE_CMD), 32'(t_cmd[op]));
            chk("wb_en", 32'(WB_EN), 32'(t_wb[op]));
            chk("mem_r_en", 32'(MEM_R_EN), 32'(t_mr[op]));
            chk("mem_w_en", 32'(MEM_W_EN), 32'(t_mw[op]));
            chk("branch_type", 32'(Branch_Type), 32'(t_bt[op]));
            chk("br_taken", 32'(Br_Taken), 32'(e_bt));
        end
    endtask

    // advance one edge and apply the same edge to the model
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else if (WB_Write_Enable && (WB_Dest != 5'd0)) begin
            m_rf[WB_Dest] = WB_Data;
        end
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        cyc(32'd0, 1'b1, idx, data, 1'b0, 1'b1);
        tick();
    endtask

    function automatic logic [31:0] mk_r(input int op, input int rd, input int rs, input int rt);
        return {6'(op), 5'(rd), 5'(rs), 5'(rt), 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input int op, input int rd, input int rs, input int im);
        return {6'(op), 5'(rd), 5'(rs), 16'(im)};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) set_op(i, 4'b0000, 0, 0, 0, 2'b00, 0, 0);
        set_op(1,  4'b0000, 1, 0, 0, 2'b00, 0, 0);
        set_op(3,  4'b0010, 1, 0, 0, 2'b00, 0, 0);
        set_op(5,  4'b0100, 1, 0, 0, 2'b00, 0, 0);
        set_op(6,  4'b0101, 1, 0, 0, 2'b00, 0, 0);
        set_op(7,  4'b0110, 1, 0, 0, 2'b00, 0, 0);
        set_op(8,  4'b0111, 1, 0, 0, 2'b00, 0, 0);
        set_op(9,  4'b1000, 1, 0, 0, 2'b00, 0, 0);
        set_op(10, 4'b1000, 1, 0, 0, 2'b00, 0, 0);
        set_op(11, 4'b1001, 1, 0, 0, 2'b00, 0, 0);
        set_op(12, 4'b1010, 1, 0, 0, 2'b00, 0, 0);
        set_op(32, 4'b0000, 1, 0, 0, 2'b00, 1, 0);
        set_op(33, 4'b0010, 1, 0, 0, 2'b00, 1, 0);
        set_op(36, 4'b0000, 1, 1, 0, 2'b00, 1, 0);
        set_op(37, 4'b0000, 0, 0, 1, 2'b00, 1, 1);
        set_op(40, 4'b0000, 0, 0, 0, 2'b01, 1, 1);
        set_op(41, 4'b0000, 0, 0, 0, 2'b10, 1, 1);
        set_op(42, 4'b0000, 0, 0, 0, 2'b11, 1, 0);
        valid_ops = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
                      6'd11, 6'd12, 6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42};
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;

        // power-up reset: register contents are unknown, so no checks yet
        @(posedge clk); #1;
        cyc(32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        tick();

        // fill some registers, then reset with a same-cycle write that must be dropped
        for (int i = 1; i < 8; i++) wr(5'(i), 32'hA5A50000 + 32'(i));
        cyc(32'd0, 1'b1, 5'd9, 32'hDEADBEEF, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 32; i++) begin
            cyc(mk_r(0, i, i, i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
            chk("rst_val1", Val1, 32'd0);
            chk("rst_val2", Val2, 32'd0);
            chk("rst_reg2", Reg2, 32'd0);
            tick();
        end

        // ADD R1 = R2 + R3
        wr(5'd2, 32'd5);
        wr(5'd3, 32'd7);
        cyc(mk_r(1, 1, 2, 3), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("add_val1", Val1, 32'd5);
        chk("add_val2", Val2, 32'd7);
        chk("add_dest", 32'(Dest), 32'd1);
        chk("add_wb_en", 32'(WB_EN), 32'd1);
        tick();

        // ADDI sign extension
        cyc(mk_i(32, 1, 2, 16'hFFFE), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("addi_val2", Val2, 32'hFFFFFFFE);
        tick();

        // ST uses rd as the second source register
        wr(5'd4, 32'd9);
        cyc(mk_i(37, 4, 2, 8), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("st_reg2", Reg2, 32'd9);
        chk("st_val2", Val2, 32'd8);
        chk("st_mem_w_en", 32'(MEM_W_EN), 32'd1);
        chk("st_wb_en", 32'(WB_EN), 32'd0);
        tick();

        // write-first bypass, then a write to R0 that must not stick
        cyc(mk_r(1, 1, 2, 3), 1'b1, 5'd2, 32'h1234, 1'b0, 1'b1);
        chk("bypass_val1", Val1, 32'h1234);
        tick();
        cyc(mk_r(1, 1, 2, 3), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("after_bypass_val1", Val1, 32'h1234);
        tick();
        cyc(mk_r(1, 1, 0, 0), 1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 1'b1);
        chk("r0_write_val1", Val1, 32'd0);
        tick();
        cyc(mk_r(1, 0, 0, 0), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("r0_read_val1", Val1, 32'd0);
        chk("r0_read_val2", Val2, 32'd0);
        tick();

        // branches
        wr(5'd2, 32'd0);
        cyc(mk_i(40, 4, 2, 3), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("bez_type", 32'(Branch_Type), 32'd1);
`ifdef ID_EARLY_BRANCH_EN
        chk("bez_taken", 32'(Br_Taken), 32'd1);
`else
        chk("bez_taken", 32'(Br_Taken), 32'd0);
`endif
        tick();
        wr(5'd2, 32'd5);
        wr(5'd4, 32'd5);
        cyc(mk_i(41, 4, 2, 3), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("bne_type", 32'(Branch_Type), 32'd2);
        chk("bne_taken", 32'(Br_Taken), 32'd0);
        tick();
        cyc(mk_i(42, 0, 0, 16), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("jmp_type", 32'(Branch_Type), 32'd3);
`ifdef ID_EARLY_BRANCH_EN
        chk("jmp_taken", 32'(Br_Taken), 32'd1);
`else
        chk("jmp_taken", 32'(Br_Taken), 32'd0);
`endif
        tick();

        // undefined opcode decodes as NOP
        cyc(mk_r(63, 1, 2, 4), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("op63_wb_en", 32'(WB_EN), 32'd0);
        chk("op63_mem_r_en", 32'(MEM_R_EN), 32'd0);
        chk("op63_mem_w_en", 32'(MEM_W_EN), 32'd0);
        chk("op63_type", 32'(Branch_Type), 32'd0);
        chk("op63_taken", 32'(Br_Taken), 32'd0);
        tick();

        // randomized traffic against the model; small register indices force bypass hits
        for (int n = 0; n < 300; n++) begin
            logic [5:0]  op;
            logic [31:0] instr, wdata;
            logic        we, r;
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = valid_ops[$urandom_range(0, 17)];
            instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 11'($urandom)};
            if ($urandom_range(0, 3) == 0) instr[15:0] = 16'($urandom);
            wdata = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            we = 1'($urandom);
            r  = ($urandom_range(0, 39) == 0);
            cyc(instr, we, 5'($urandom_range(0, 7)), wdata, r, 1'b1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
